// File: rtl/cls_sched_pkg.sv
// Shared types and constants for the classifier scheduler.
package cls_sched_pkg;

  localparam int CLASS_W = 2;
  localparam int PIXEL_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic int pixel_count(input int image_size);
    return image_size * image_size;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Pointing at the last requester makes requester 0 the first candidate.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win_idx, cand_idx;
  logic             found;
  int               cand;

  always_comb begin
    grant    = '0;
    win_idx  = last_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
    if (found) grant[win_idx] = 1'b1;
    last_d = (accept && found) ? win_idx : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= LAST_RST;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/classifier_scheduler.sv
// Shares one image classifier between NUM_REQ requesters with round-robin grants.
// Optional WAIT watchdog enabled by defining CLS_SCHED_TIMEOUT_EN.
module classifier_scheduler
  import cls_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IMAGE_SIZE     = 28,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [PIXEL_W*NUM_REQ-1:0] req_pixel,
  input  logic [NUM_REQ-1:0]         req_pixel_valid,
  output logic [NUM_REQ-1:0]         req_pixel_ready,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [CLASS_W-1:0]         rsp_class,
  output logic                       rsp_error,
  output logic                       cls_start,
  input  logic                       cls_ready,
  output logic [PIXEL_W-1:0]         cls_pixel,
  output logic                       cls_pixel_valid,
  input  logic                       cls_done,
  input  logic [CLASS_W-1:0]         cls_class,
  output logic                       cls_rst,
  output logic                       busy
);

  localparam int PIX_TOTAL = pixel_count(IMAGE_SIZE);
  localparam int CNT_W = ($clog2(PIX_TOTAL + 1) > 10) ? $clog2(PIX_TOTAL + 1) : 10;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOTAL - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [CLASS_W-1:0]   rsp_class_q, rsp_class_d;
  logic                 cls_start_q, cls_start_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_accept;
  logic                 in_stream;
  logic [PIXEL_W-1:0]   pix_lane [NUM_REQ];
  logic [PIXEL_W-1:0]   pix_sel;
  logic                 strobe_sel;

`ifdef CLS_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rsp_error_q, rsp_error_d;
  logic            cls_rst_q, cls_rst_d;
`endif

  assign arb_accept = (state_q == S_IDLE) && cls_ready && (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (arb_accept),
    .grant  (arb_grant)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign pix_lane[gi] = req_pixel[gi*PIXEL_W +: PIXEL_W];
  end

  // grant_q is one-hot, so OR-ing the selected lanes is a plain mux.
  always_comb begin
    pix_sel    = '0;
    strobe_sel = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        pix_sel    = pix_sel | pix_lane[k];
        strobe_sel = strobe_sel | req_pixel_valid[k];
      end
    end
  end

  assign in_stream       = (state_q == S_STREAM);
  assign cls_pixel_valid = in_stream & strobe_sel;
  assign cls_pixel       = in_stream ? pix_sel : '0;
  assign req_pixel_ready = in_stream ? grant_q : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    pix_cnt_d   = pix_cnt_q;
    rsp_class_d = rsp_class_q;
    rsp_valid_d = '0;
    cls_start_d = 1'b0;
`ifdef CLS_SCHED_TIMEOUT_EN
    wd_d        = wd_q;
    rsp_error_d = rsp_error_q;
    cls_rst_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_accept) begin
          state_d     = S_START;
          grant_d     = arb_grant;
          cls_start_d = 1'b1;
        end
      end
      S_START: begin
        state_d   = S_STREAM;
        pix_cnt_d = '0;
`ifdef CLS_SCHED_TIMEOUT_EN
        wd_d      = '0;
`endif
      end
      S_STREAM: begin
        if (cls_pixel_valid) begin
          if (pix_cnt_q == PIX_LAST) begin
            state_d   = S_WAIT;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (cls_done) begin
          state_d     = S_RESP;
          rsp_class_d = cls_class;
          rsp_valid_d = grant_q;
`ifdef CLS_SCHED_TIMEOUT_EN
          rsp_error_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d     = S_RESP;
          rsp_class_d = '0;
          rsp_valid_d = grant_q;
          rsp_error_d = 1'b1;
          cls_rst_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      pix_cnt_q   <= '0;
      rsp_class_q <= '0;
      cls_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CLS_SCHED_TIMEOUT_EN
      wd_q        <= '0;
      rsp_error_q <= 1'b0;
      cls_rst_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      pix_cnt_q   <= pix_cnt_d;
      rsp_class_q <= rsp_class_d;
      cls_start_q <= cls_start_d;
      busy_q      <= busy_d;
`ifdef CLS_SCHED_TIMEOUT_EN
      wd_q        <= wd_d;
      rsp_error_q <= rsp_error_d;
      cls_rst_q   <= cls_rst_d;
`endif
    end
  end

  assign req_grant = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_class = rsp_class_q;
  assign cls_start = cls_start_q;
  assign busy      = busy_q;
`ifdef CLS_SCHED_TIMEOUT_EN
  assign rsp_error = rsp_error_q;
  assign cls_rst   = cls_rst_q;
`else
  assign rsp_error = 1'b0;
  assign cls_rst   = 1'b0;
`endif

endmodule

// File: tb/tb_classifier_scheduler.sv
// Randomized self-checking bench for classifier_scheduler against a job-level model.
module tb_classifier_scheduler;

  localparam int N   = 4;
  localparam int IMG = 28;
  localparam int PIX = IMG * IMG;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_pixel = '0;
  logic [N-1:0]   req_pixel_valid = '0;
  logic [N-1:0]   req_pixel_ready;
  logic [N-1:0]   req_grant;
  logic [N-1:0]   rsp_valid;
  logic [1:0]     rsp_class;
  logic           rsp_error;
  logic           cls_start;
  logic           cls_ready = 1'b0;
  logic [7:0]     cls_pixel;
  logic           cls_pixel_valid;
  logic           cls_done = 1'b0;
  logic [1:0]     cls_class = '0;
  logic           cls_rst;
  logic           busy;

  always #5 clk = ~clk;

  classifier_scheduler #(
    .NUM_REQ(N), .IMAGE_SIZE(IMG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pixel(req_pixel), .req_pixel_valid(req_pixel_valid),
    .req_pixel_ready(req_pixel_ready), .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_class(rsp_class), .rsp_error(rsp_error),
    .cls_start(cls_start), .cls_ready(cls_ready), .cls_pixel(cls_pixel),
    .cls_pixel_valid(cls_pixel_valid), .cls_done(cls_done), .cls_class(cls_class),
    .cls_rst(cls_rst), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int job_no = 0;
  int last_g = N - 1;
  int surplus_cap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  // Next owner: first requester after the previous owner, wrapping around.
  function automatic int model_grant(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(last_g + i) % N]) return (last_g + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [26:0] all_outputs();
    return {req_pixel_ready, req_grant, rsp_valid, rsp_class, rsp_error, cls_start,
            cls_pixel, cls_pixel_valid, cls_rst, busy};
  endfunction

  task automatic stream(input int g, input int duty, input int target, input bit drop,
                        input bit spurious, output int fwd, output int last_cyc);
    int offered = 0;
    int guard = 0;
    int bad_v = 0;
    int bad_d = 0;
    int bad_r = 0;
    bit sg;
    bit exp_f;
    logic [N-1:0] strb;
    logic [N-1:0] exp_rdy;
    fwd = 0;
    last_cyc = cyc;
    while (offered < target && guard < 4000) begin
      sg = ($urandom_range(99) < duty);
      strb = N'($urandom);
      strb[g] = sg;
      req_pixel = $urandom;
      req_pixel_valid = strb;
      if (sg) offered++;
      if (drop && offered == target / 2) req_valid = '0;
      cls_done = spurious && sg && offered == 100;
      cls_class = 2'd3;
      #1;
      exp_f = sg && (fwd < PIX);
      exp_rdy = (fwd < PIX) ? onehot(g) : '0;
      if (cls_pixel_valid !== exp_f) bad_v++;
      if (exp_f && cls_pixel !== req_pixel[8*g +: 8]) bad_d++;
      if (req_pixel_ready !== exp_rdy) bad_r++;
      if (exp_f) begin
        fwd++;
        last_cyc = cyc;
      end
      tick;
      guard++;
    end
    req_pixel_valid = '0;
    cls_done = 1'b0;
    check("stream_offered", offered, target);
    check("pix_valid_errs", bad_v, 0);
    check("pix_data_errs", bad_d, 0);
    check("pix_ready_errs", bad_r, 0);
  endtask

  task automatic run_job(input logic [N-1:0] reqs, input int delay, input int duty,
                         input int target, input bit drop, input bit spurious,
                         input bit timeout, input logic [1:0] cls);
    int g, fwd, lc, bp, nrsp, waitn, guard;
    logic [N:0] exp_wait;
    req_valid = reqs;
    cls_ready = (delay == 0);
    bp = 0;
    repeat (delay) begin
      tick;
      if (req_grant !== '0 || busy !== 1'b0) bp++;
    end
    if (delay > 0) begin
      check("backpressure_idle", bp, 0);
      cls_ready = 1'b1;
    end
    g = model_grant(reqs);
    last_g = g;
    tick;
    check("grant", req_grant, onehot(g));
    check("start_busy", {cls_start, busy}, 2'b11);
    tick;
    check("start_one_cycle", cls_start, 0);
    stream(g, duty, target, drop, spurious, fwd, lc);
    check("forwarded", fwd, PIX);
    exp_wait = {N'(0), 1'b1};
    check("wait_ready_busy", {req_pixel_ready, busy}, exp_wait);
    if (!timeout) begin
      nrsp = 0;
      waitn = $urandom_range(4);
      repeat (waitn) begin
        if (rsp_valid !== '0) nrsp++;
        tick;
      end
      cls_done = 1'b1;
      cls_class = cls;
      tick;
      cls_done = 1'b0;
      check("early_rsp", nrsp, 0);
      check("rsp_valid", rsp_valid, onehot(g));
      check("rsp_class", rsp_class, cls);
      check("rsp_err_rst", {rsp_error, cls_rst}, 0);
    end else begin
      guard = 0;
      while (cls_rst !== 1'b1 && guard < 40) begin
        tick;
        guard++;
      end
      check("timeout_latency", cyc - lc, TO + 1);
      check("timeout_rsp_valid", rsp_valid, onehot(g));
      check("timeout_err_class", {rsp_error, rsp_class}, 3'b100);
    end
    check("grant_in_resp", req_grant, onehot(g));
    tick;
    check("resp_done", {rsp_valid, req_grant, busy, cls_rst}, 0);
    job_no++;
    $display("job %0d: reqs=%b grant=%0d fwd=%0d class=%0d err=%0d", job_no, reqs, g, fwd,
             timeout ? 0 : cls, timeout);
  endtask

  initial begin
    int g, fwd, lc;
    logic [N-1:0] r;
`ifdef CLS_SCHED_TIMEOUT_EN
    surplus_cap = 0;
`else
    surplus_cap = 16;
`endif
    repeat (3) tick;
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    tick;

    run_job(4'b0001, 0, 100, PIX, 0, 0, 0, 2'd2);
    repeat (4) run_job(4'b1111, 0, 100, PIX, 0, 0, 0, 2'($urandom));
    run_job(4'b0010, 5, 100, PIX, 0, 0, 0, 2'd1);
    run_job(4'b0001, 0, 50, PIX + surplus_cap, 0, 1, 0, 2'd3);
    run_job(4'b1010, 0, 80, PIX, 1, 0, 0, 2'd0);

    // Abandon a job mid-stream with reset.
    req_valid = 4'b0100;
    cls_ready = 1'b1;
    g = model_grant(req_valid);
    last_g = g;
    tick;
    check("rst_job_grant", req_grant, onehot(g));
    tick;
    stream(g, 100, 300, 0, 0, fwd, lc);
    check("rst_job_fwd", fwd, 300);
    req_pixel_valid = '1;
    rst = 1'b1;
    tick;
    check("midjob_reset_outputs", all_outputs(), 0);
    req_valid = '0;
    req_pixel_valid = '0;
    rst = 1'b0;
    last_g = N - 1;
    tick;
    check("post_reset_no_rsp", {rsp_valid, busy}, 0);
    run_job(4'b1111, 0, 100, PIX, 0, 0, 0, 2'd2);

    for (int j = 0; j < 3; j++) begin
      r = N'($urandom_range(15, 1));
      run_job(r, $urandom_range(2), $urandom_range(100, 50),
              PIX + (surplus_cap > 0 ? $urandom_range(surplus_cap) : 0),
              1'($urandom_range(1)), 0, 0, 2'($urandom));
    end

`ifdef CLS_SCHED_TIMEOUT_EN
    run_job(4'b0100, 0, 100, PIX, 0, 0, 1, 2'd0);
    run_job(4'b1111, 0, 100, PIX, 0, 0, 0, 2'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
